// File: rtl/dram_lsu.sv
`default_nettype none
// ============================================================================
// Module   : dram_lsu
// Purpose  : Load/store front-end for the 256 x 32 data_ram block RAM
//            (port A). Takes one byte/half/word access at a time over a
//            valid/ready handshake, drives byte-lane write enables, word
//            address and lane-replicated write data, and returns one
//            response per request with sign/zero-extended load data.
// Ports    : clk, reset          - clock (shared with data_ram clka), sync
//                                  active-high reset
//            req_*               - upstream request (valid/ready, wr, size,
//                                  unsigned, byte addr, right-aligned wdata)
//            rsp_*               - upstream response (valid/ready, rdata, err)
//            ram_wea/addr/din    - to data_ram wea/addra/dina
//            ram_dout            - from data_ram douta (1-cycle registered)
// Config   : DRAM_LSU_ALIGN_CHECK_EN - when defined, misaligned half/word
//            accesses and size=3 return rsp_err=1 without touching the RAM;
//            when undefined, low address bits are forced to alignment and
//            size=3 behaves as a word access.
// Revision : 1.0 - initial release
// ============================================================================
module dram_lsu (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [3:0]  ram_wea,
  output logic [7:0]  ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_wr;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [1:0]  r_off;
  logic        r_err;
  logic [3:0]  r_wea;
  logic [7:0]  r_addr;
  logic [31:0] r_din;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic [31:0] w_addr_eff;
  logic [1:0]  w_size_eff;
  logic        w_misalign;
  logic [3:0]  w_wea_req;
  logic [31:0] w_din_req;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic        w_unused;

  // Upper address bits are ignored: the RAM window wraps every 1 KiB.
  assign w_unused = ^req_addr[31:10];

  // Alignment policy applied to the incoming request.
  always_comb begin
    w_addr_eff = req_addr;
    w_size_eff = req_size;
`ifdef DRAM_LSU_ALIGN_CHECK_EN
    w_misalign = ((req_size == 2'd1) && req_addr[0]) ||
                 ((req_size == 2'd2) && (req_addr[1:0] != 2'b00)) ||
                 (req_size == 2'd3);
`else
    w_misalign = 1'b0;
    if (req_size == 2'd3) begin
      w_size_eff = 2'd2;
    end
    case (w_size_eff)
      2'd1:    w_addr_eff[0]   = 1'b0;
      2'd2:    w_addr_eff[1:0] = 2'b00;
      default: ;
    endcase
`endif
  end

  // Byte-lane enables and lane-replicated data for a store.
  always_comb begin
    w_wea_req = 4'b0000;
    w_din_req = req_wdata;
    case (w_size_eff)
      2'd0: begin
        w_wea_req = 4'b0001 << w_addr_eff[1:0];
        w_din_req = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        w_wea_req = w_addr_eff[1] ? 4'b1100 : 4'b0011;
        w_din_req = {2{req_wdata[15:0]}};
      end
      default: begin
        w_wea_req = 4'b1111;
        w_din_req = req_wdata;
      end
    endcase
    if (!req_wr || w_misalign) begin
      w_wea_req = 4'b0000;
    end
  end

  // Lane selection and extension of the word read back from the RAM.
  always_comb begin
    case (r_off)
      2'd0:    w_byte = ram_dout[7:0];
      2'd1:    w_byte = ram_dout[15:8];
      2'd2:    w_byte = ram_dout[23:16];
      default: w_byte = ram_dout[31:24];
    endcase
    w_half = r_off[1] ? ram_dout[31:16] : ram_dout[15:0];
    case (r_size)
      2'd0:    w_load = r_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'd1:    w_load = r_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = ram_dout;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wr        <= 1'b0;
      r_size      <= 2'd0;
      r_uns       <= 1'b0;
      r_off       <= 2'd0;
      r_err       <= 1'b0;
      r_wea       <= 4'b0000;
      r_addr      <= 8'd0;
      r_din       <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_wr   <= req_wr;
            r_size <= w_size_eff;
            r_uns  <= req_unsigned;
            r_off  <= w_addr_eff[1:0];
            r_err  <= w_misalign;
            // Address/enables/data are set up at the accept edge so they
            // are already on the RAM pins throughout the ACCESS cycle.
            r_addr <= w_addr_eff[9:2];
            r_wea  <= w_wea_req;
            if (req_wr && !w_misalign) begin
              r_din <= w_din_req;
            end
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_wea <= 4'b0000;
          if (r_err || r_wr) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= r_err;
            r_state     <= S_RESP;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= w_load;
          r_rsp_err   <= 1'b0;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Reset must suppress a write already set up for the current cycle.
  assign ram_wea   = reset ? 4'b0000 : r_wea;
  assign req_ready = (r_state == S_IDLE) && !reset;
  assign ram_addr  = r_addr;
  assign ram_din   = r_din;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_dram_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_lsu
// Purpose  : Self-checking bench for dram_lsu with a behavioural 256 x 32
//            byte-enable RAM (registered read). Responses are checked against
//            a queue of expected results pushed at each accept edge.
// Config   : DRAM_LSU_ALIGN_CHECK_EN selects the expected error behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dram_lsu;

`ifdef DRAM_LSU_ALIGN_CHECK_EN
  localparam logic C_ALIGN = 1'b1;
`else
  localparam logic C_ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [3:0]  ram_wea;
  logic [7:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  logic [31:0] mem [256];

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t        tbl [$];
  logic [32:0] sb  [$];

  always #5 clk = ~clk;

  dram_lsu u_dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .ram_wea      (ram_wea),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout)
  );

  // Behavioural data_ram port A: byte writes, read-first registered output.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (ram_wea[k]) mem[ram_addr][8*k +: 8] <= ram_din[8*k +: 8];
    end
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: compare every response at the negedge before its handshake.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e[31:0]);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
      end
    end
  end

  task automatic add(input logic wr, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    tbl.push_back(v);
  endtask

  // Called just after a posedge; returns 1 ns after the accept edge (cycle 1).
  task automatic send(input logic wr, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err,
                      input bit push);
    bit got;
    req_valid = 1'b1; req_wr = wr; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (req_ready) got = 1'b1;
    end
    if (!got) chk("req_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    if (push) sb.push_back({exp_err, exp_rdata});
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b1;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_ram_wea", {28'd0, ram_wea}, 32'd0);
    chk("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;

    // ---- SW timing: wea in cycle 1, rsp in cycle 2 ----
    send(1'b1, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("sw_c1_wea", {28'd0, ram_wea}, 32'hF);
    chk("sw_c1_addr", {24'd0, ram_addr}, 32'h04);
    chk("sw_c1_din", ram_din, 32'hDEADBEEF);
    chk("sw_c1_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("sw_c2_valid", {31'd0, rsp_valid}, 32'd1);
    chk("sw_c2_wea", {28'd0, ram_wea}, 32'd0);
    drain();

    // ---- LW timing: rsp in cycle 3 ----
    send(1'b0, 2'd2, 1'b0, 32'h010, 32'd0, 32'hDEADBEEF, 1'b0, 1'b1);
    @(negedge clk);
    chk("lw_c1_wea", {28'd0, ram_wea}, 32'd0);
    chk("lw_c1_addr", {24'd0, ram_addr}, 32'h04);
    @(negedge clk);
    chk("lw_c2_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("lw_c3_valid", {31'd0, rsp_valid}, 32'd1);
    drain();

    send(1'b1, 2'd2, 1'b0, 32'h004, 32'hCAFEF00D, 32'd0, 1'b0, 1'b1);
    send(1'b1, 2'd2, 1'b0, 32'h010, 32'h11223344, 32'd0, 1'b0, 1'b1);
    drain();

    // ---- SB onto 0x11223344: lane 3, replicated data ----
    send(1'b1, 2'd0, 1'b0, 32'h013, 32'h000000A5, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("sb_wea", {28'd0, ram_wea}, 32'h8);
    chk("sb_din", ram_din, 32'hA5A5A5A5);
    drain();

    // ---- SH upper half ----
    send(1'b1, 2'd1, 1'b0, 32'h022, 32'h00008001, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("sh_wea", {28'd0, ram_wea}, 32'hC);
    chk("sh_din", ram_din, 32'h80018001);
    chk("sh_addr", {24'd0, ram_addr}, 32'h08);
    drain();

    // ---- table-driven accesses ----
    add(1'b0, 2'd2, 1'b0, 32'h010, 32'd0, 32'hA5223344, 1'b0);
    add(1'b0, 2'd0, 1'b0, 32'h013, 32'd0, 32'hFFFFFFA5, 1'b0);
    add(1'b0, 2'd0, 1'b1, 32'h013, 32'd0, 32'h000000A5, 1'b0);
    add(1'b0, 2'd0, 1'b0, 32'h011, 32'd0, 32'h00000033, 1'b0);
    add(1'b0, 2'd1, 1'b1, 32'h010, 32'd0, 32'h00003344, 1'b0);
    add(1'b0, 2'd1, 1'b0, 32'h012, 32'd0, 32'hFFFFA522, 1'b0);
    add(1'b0, 2'd1, 1'b0, 32'h022, 32'd0, 32'hFFFF8001, 1'b0);
    add(1'b0, 2'd1, 1'b1, 32'h022, 32'd0, 32'h00008001, 1'b0);
    add(1'b0, 2'd2, 1'b0, 32'h020, 32'd0, 32'h80010000, 1'b0);
    add(1'b0, 2'd2, 1'b0, 32'h410, 32'd0, 32'hA5223344, 1'b0);
    add(1'b1, 2'd0, 1'b0, 32'h021, 32'h0000007F, 32'd0, 1'b0);
    add(1'b0, 2'd2, 1'b0, 32'h020, 32'd0, 32'h80017F00, 1'b0);
    add(1'b0, 2'd2, 1'b0, 32'h005, 32'd0, C_ALIGN ? 32'd0 : 32'hCAFEF00D, C_ALIGN);
    add(1'b0, 2'd3, 1'b0, 32'h010, 32'd0, C_ALIGN ? 32'd0 : 32'hA5223344, C_ALIGN);
    add(1'b1, 2'd1, 1'b0, 32'h023, 32'h00001234, 32'd0, C_ALIGN);
    add(1'b0, 2'd2, 1'b0, 32'h020, 32'd0, C_ALIGN ? 32'h80017F00 : 32'h12347F00, 1'b0);
    add(1'b0, 2'd0, 1'b0, 32'h022, 32'd0, C_ALIGN ? 32'h00000001 : 32'h00000034, 1'b0);
    for (int i = 0; i < tbl.size(); i++) begin
      send(tbl[i].wr, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
           tbl[i].exp_rdata, tbl[i].exp_err, 1'b1);
    end
    drain();

    // ---- misaligned LW: error in cycle 2 (checked build) or normal load ----
    send(1'b0, 2'd2, 1'b0, 32'h005, 32'd0, C_ALIGN ? 32'd0 : 32'hCAFEF00D, C_ALIGN, 1'b1);
    @(negedge clk);
    chk("mis_c1_wea", {28'd0, ram_wea}, 32'd0);
    @(negedge clk);
    chk("mis_c2_wea", {28'd0, ram_wea}, 32'd0);
    chk("mis_c2_valid", {31'd0, rsp_valid}, {31'd0, C_ALIGN});
    drain();

    // ---- response stall for 5 cycles, then back-to-back accept ----
    rsp_ready = 1'b0;
    send(1'b0, 2'd2, 1'b0, 32'h010, 32'd0, 32'hA5223344, 1'b0, 1'b1);
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_rdata", rsp_rdata, 32'hA5223344);
      chk("stall_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    req_valid = 1'b1; req_wr = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h004; req_wdata = 32'd0;
    @(negedge clk);
    chk("hs_cycle_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_hs_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    sb.push_back({1'b0, 32'hCAFEF00D});
    #1 req_valid = 1'b0;
    drain();

    // ---- reset in a store's ACCESS cycle aborts the write ----
    send(1'b1, 2'd2, 1'b0, 32'h010, 32'h55555555, 32'd0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_wea", {28'd0, ram_wea}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_rsp_rdata", rsp_rdata, 32'd0);
    chk("abort_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("abort_ram_wea", {28'd0, ram_wea}, 32'd0);
    chk("abort_ram_addr", {24'd0, ram_addr}, 32'd0);
    chk("abort_ram_din", ram_din, 32'd0);
    @(posedge clk); #1;
    send(1'b0, 2'd2, 1'b0, 32'h010, 32'd0, 32'hA5223344, 1'b0, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/dram_lsu.md
# dram_lsu

Load/store front-end for the 256 x 32 `data_ram` block RAM (port A), with byte-lane write enables and a registered 1-cycle read.
- Accepts one byte, halfword or word access at a time over a valid/ready handshake.
- Drives the RAM's byte-lane write enables, word address and replicated write data.
- Extracts and sign- or zero-extends load data.
- Returns one response per request.
- Sits between the CPU memory stage (upstream) and `data_ram` (downstream).

## Interface
- No parameters. RAM geometry is fixed: 256 words, 4 byte lanes.
- `clk` in 1 — single clock, shared with RAM port A (`clka`).
- `reset` in 1 — synchronous, active-high.
- `req_valid` in 1 — request present.
- `req_ready` out 1 — block can accept a request.
- `req_wr` in 1 — 1 = store, 0 = load.
- `req_size` in 2 — 0 byte, 1 half, 2 word, 3 illegal.
- `req_unsigned` in 1 — zero-extend loads; ignored for stores.
- `req_addr` in 32 — byte address.
- `req_wdata` in 32 — store data, right-aligned.
- `rsp_valid` out 1 — response present.
- `rsp_ready` in 1 — consumer takes the response.
- `rsp_rdata` out 32 — extended load data; 0 for stores and errors.
- `rsp_err` out 1 — misaligned access or illegal size; the access was not performed.
- `ram_wea` out 4 — to `data_ram.wea`.
- `ram_addr` out 8 — to `data_ram.addra`.
- `ram_din` out 32 — to `data_ram.dina`.
- `ram_dout` in 32 — from `data_ram.douta`.

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid` & `req_ready`, latch wr/size/unsigned/addr/wdata, then go to ACCESS.
- **ACCESS**
  - `ram_addr` = latched addr[9:2]; addr[31:10] are ignored, so addresses wrap modulo 1 KiB.
  - Store: drive `ram_wea` and `ram_din`, then go to RESP.
  - Load: `ram_wea`=0, then go to WAIT.
  - Error (see Configuration): `ram_wea`=0, then go straight to RESP with the error flag set.
- **WAIT**
  - Capture `ram_dout` and extend it into the response register, then go to RESP.
- **RESP**
  - `rsp_valid`=1, with `rsp_rdata`/`rsp_err` held stable.
  - On `rsp_ready`, go to IDLE.
- Byte lanes are little-endian: byte k = bits [8k+7:8k], enabled by `ram_wea[k]`.
- Store enables:
  - byte: one-hot on lane addr[1:0].
  - half: 0011 when addr[1]=0, 1100 when addr[1]=1.
  - word: 1111.
- Store data is replicated: byte `{4{wdata[7:0]}}`, half `{2{wdata[15:0]}}`, word `wdata`.
- Load extraction: select the lane(s) by addr[1:0], then sign-extend from bit 7/15, or zero-extend when `req_unsigned`=1.
- `ram_wea`=0 in every state except a store's ACCESS cycle.
- `ram_addr` and `ram_din` hold their last values outside ACCESS.
- Reset values:
  - state IDLE.
  - `req_ready`=0 while `reset`=1, otherwise 1 in IDLE.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - `ram_wea`=0, `ram_addr`=0, `ram_din`=0.
- Reset during any state aborts the access:
  - `ram_wea` is forced 0 in that cycle, so no write occurs.
  - Any pending response is discarded.

## Timing
- Cycle 0 is the accept edge.
- Load: ACCESS in cycle 1 (RAM samples the address at the end of cycle 1), WAIT in cycle 2 (`ram_dout` valid), `rsp_valid` in cycle 3. Load-to-response latency is 3 cycles.
- Store: write enable in cycle 1, `rsp_valid` in cycle 2.
- Error: `rsp_valid` in cycle 2.
- A new request is accepted no earlier than the cycle after the response handshake. Peak throughput is one load per 4 cycles and one store per 3 cycles.
- `req_ready` is 0 in ACCESS, WAIT and RESP; no request is buffered.
- `rsp_ready` held low stalls in RESP indefinitely with outputs stable.
- A load that follows a store to the same word returns the new data, because the store's write completes before the load's ACCESS.

## Configuration
- `DRAM_LSU_ALIGN_CHECK_EN` defined:
  - A halfword access with addr[0]=1, a word access with addr[1:0]≠0, or size=3 sets `rsp_err`=1 and performs no RAM write.
- `DRAM_LSU_ALIGN_CHECK_EN` undefined:
  - Low address bits below the access size are forced to 0 (half: addr[0], word: addr[1:0]).
  - size=3 is treated as word.
  - `rsp_err` is tied 0.

## Test plan
- After reset, SW addr 0x010 data 0xDEADBEEF, then LW 0x010 → `ram_wea`=1111 and `ram_addr`=0x04 in cycle 1; load response 0xDEADBEEF in cycle 3.
- SB 0x013 data 0x000000A5 onto word 0x11223344, then LB 0x013 / LBU 0x013 → `ram_wea`=1000, `ram_din`=0xA5A5A5A5; word becomes 0xA5223344; LB → 0xFFFFFFA5, LBU → 0x000000A5.
- SH 0x022 data 0x8001, then LH 0x022 / LHU 0x022 → `ram_wea`=1100; LH → 0xFFFF8001, LHU → 0x00008001.
- With the macro defined, LW 0x005 → `rsp_err`=1 in cycle 2 and `ram_wea` never asserted. With the macro undefined, the same load reads word 0x01.
- LW with `rsp_ready` low for 5 cycles → `rsp_valid` held, data stable, `req_ready`=0 throughout; the next request is accepted one cycle after the handshake.
- SW asserted with `reset` pulsed in its ACCESS cycle, then LW of the same address → no write (old data returned); all outputs at reset values the cycle after reset.
